// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Owner index width helper and burst-beat counter width.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam int BEAT_CNT_W = 4;

  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Producer/FIFO-side bundle of the write arbiter.
// master = producers and FIFO, slave = arbiter.
interface fifo_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int OW = fifo_arb_pkg::owner_w(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      fifo_full;
  logic                      fifo_wr_en;
  logic [DATA_W-1:0]         fifo_wr_data;
  logic [OW-1:0]             grant_id;
  logic                      busy;
  logic [15:0]               stall_cnt;

  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_wr_en, fifo_wr_data,
    input  grant_id, busy, stall_cnt
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_wr_en, fifo_wr_data,
    output grant_id, busy, stall_cnt
  );

endinterface

// File: rtl/fifo_write_arbiter_rr_select.sv
// Combinational round-robin finder: first set request
// strictly after last_owner, wrapping modulo NUM_REQ.
module rr_select
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int OW = owner_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OW-1:0]      last_owner,
  output logic               any,
  output logic [OW-1:0]      idx
);

  always_comb begin
    int j;
    j   = 0;
    any = 1'b0;
    idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      j = int'(last_owner) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any && req[j]) begin
        any = 1'b1;
        idx = OW'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter for the byte FIFO write port.
// Define FIFO_ARB_STATS_EN to build the full-stall counter.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 4
) (
  input logic                 clk,
  input logic                 rst,
  fifo_write_arbiter_if.slave bus
);

  localparam int OW = owner_w(NUM_REQ);
  localparam logic [BEAT_CNT_W-1:0] BMAX =
    BEAT_CNT_W'(BURST_MAX);

  state_t                state_q, state_d;
  logic [OW-1:0]         owner_q, owner_d;
  logic [OW-1:0]         ptr_q, ptr_d;
  logic [BEAT_CNT_W-1:0] beat_q, beat_d;
  logic [OW-1:0]         sel_idx;
  logic                  sel_any;
  logic                  beat, burst_end;
  logic                  own_valid, own_last;
  logic [DATA_W-1:0]     own_data;
  logic [NUM_REQ-1:0]    ready;

  rr_select #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (bus.req_valid),
    .last_owner (ptr_q),
    .any        (sel_any),
    .idx        (sel_idx)
  );

  assign own_valid = bus.req_valid[owner_q];
  assign own_last  = bus.req_last[owner_q];
  assign own_data  =
    bus.req_data[int'(owner_q)*DATA_W +: DATA_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= OW'(NUM_REQ - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
    end
  end

  // req_last only counts on an accepted beat
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    beat_d    = beat_q;
    beat      = 1'b0;
    burst_end = 1'b0;
    ready     = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (sel_any) begin
          owner_d = sel_idx;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        ready[owner_q] = ~bus.fifo_full;
        beat = own_valid & ~bus.fifo_full;
        burst_end = beat &
          (own_last | (beat_q + BEAT_CNT_W'(1) == BMAX));
        if (burst_end) begin
          state_d = ST_IDLE;
          ptr_d   = owner_q;
          beat_d  = '0;
        end else if (beat) begin
          beat_d = beat_q + BEAT_CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.req_ready    = ready;
  assign bus.fifo_wr_en   = beat;
  assign bus.fifo_wr_data = beat ? own_data : '0;
  assign bus.grant_id     = owner_q;
  assign bus.busy         = (state_q == ST_BURST);

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (state_q == ST_BURST && own_valid &&
                 bus.fifo_full && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign bus.stall_cnt = stall_q;
`else
  assign bus.stall_cnt = '0;
`endif

endmodule
